// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter sequencer.
// Op codes 6 and 7 are left unnamed; the sequencer treats them as increment.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_JUMP   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } pc_state_e;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_OVF  = 2'd1;
  localparam logic [1:0] FC_UNF  = 2'd2;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: small LIFO whose top entry is always visible on rdata.
// Push when full and pop when empty are ignored; the caller turns them into faults.
module pc_ras #(
  parameter int AW        = 16,
  parameter int RAS_DEPTH = 4,
  localparam int CW = $clog2(RAS_DEPTH + 1),
  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] stack [RAS_DEPTH];
  logic [IW-1:0] wrIdx;
  logic [IW-1:0] rdIdx;

  assign full  = (count == CW'(RAS_DEPTH));
  assign empty = (count == '0);
  assign wrIdx = IW'(count);
  assign rdIdx = IW'(count - CW'(1));
  assign rdata = stack[rdIdx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // Entries need no reset: nothing is read below count.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      stack[wrIdx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with stall, jump, relative branch and call/return.
// state    | meaning
// ST_RUN   | ops sampled when en=1
// ST_FAULT | stack misuse trapped; pc/stack/code frozen until clr_fault
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int AW        = 16,
  parameter int RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter logic [AW-1:0] TRAP_ADDR  = AW'(16'hFFF0)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [2:0]                       op,
  input  logic                             cond,
  input  logic [AW-1:0]                    target,
  input  logic [AW-1:0]                    offset,
  input  logic                             clr_fault,
  output logic [AW-1:0]                    pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             fault,
  output logic [1:0]                       fault_code
);

  pc_state_e     state, stateNext;
  logic [AW-1:0] pcNext;
  logic [AW-1:0] pcInc;
  logic [1:0]    codeNext;
  logic          rasPush, rasPop, rasFull, rasEmpty;
  logic [AW-1:0] rasRdata;

  assign pcInc = pc + AW'(1);
  assign fault = (state == ST_FAULT);

  pc_ras #(.AW(AW), .RAS_DEPTH(RAS_DEPTH)) uRas (
    .clk   (clk),
    .rst   (rst),
    .push  (rasPush),
    .pop   (rasPop),
    .wdata (pcInc),
    .rdata (rasRdata),
    .count (ras_count),
    .full  (rasFull),
    .empty (rasEmpty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      pc         <= RESET_ADDR;
      fault_code <= FC_NONE;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      fault_code <= codeNext;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    codeNext  = fault_code;
    rasPush   = 1'b0;
    rasPop    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (en) begin
          case (op)
            OP_HOLD:   pcNext = pc;
            OP_JUMP:   pcNext = target;
            OP_BRANCH: pcNext = cond ? (pc + offset) : pcInc;
            OP_CALL: begin
              if (rasFull) begin
                stateNext = ST_FAULT;
                codeNext  = FC_OVF;
                pcNext    = TRAP_ADDR;
              end else begin
                rasPush = 1'b1;
                pcNext  = target;
              end
            end
            OP_RET: begin
              if (rasEmpty) begin
                stateNext = ST_FAULT;
                codeNext  = FC_UNF;
                pcNext    = TRAP_ADDR;
              end else begin
                rasPop = 1'b1;
                pcNext = rasRdata;
              end
            end
            default:   pcNext = pcInc;
          endcase
        end
      end
      ST_FAULT: begin
        // Clearing takes the whole cycle; any op presented alongside is dropped.
        if (clr_fault) begin
          stateNext = ST_RUN;
          codeNext  = FC_NONE;
        end
      end
      default: stateNext = ST_RUN;
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised, clocked program counter for the puzzle-module microcontroller core. Replaces the free-running increment/set counter with a registered PC that supports stall, increment, absolute jump, conditional relative branch, and call/return through an internal return-address stack (RAS). Stack misuse is detected and reported. The instruction fetch stage consumes `pc` directly.

## Interface
- `AW`, 16: address width in bits.
- `RAS_DEPTH`, 4: return-address stack entries (≥1).
- `RESET_ADDR`, 0: `pc` value after reset.
- `TRAP_ADDR`, 16'hFFF0: `pc` value on stack fault (truncated to AW).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; 0 = stall, `op` ignored.
- `op`  in  3  operation code, sampled when `en`=1.
- `cond`  in  1  branch condition for BRANCH.
- `target`  in  AW  absolute address for JUMP and CALL.
- `offset`  in  AW  two's-complement displacement for BRANCH.
- `clr_fault`  in  1  leave FAULT state.
- `pc`  out  AW  current instruction address (registered).
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid stack entries.
- `fault`  out  1  high while in FAULT.
- `fault_code`  out  2  0 none, 1 overflow, 2 underflow.

## Operation
- Ops: 0 HOLD (pc unchanged); 1 INC (pc+1); 2 JUMP (pc=target); 3 BRANCH (cond ? pc+offset : pc+1); 4 CALL (push pc+1, pc=target); 5 RET (pc=pop); 6, 7 reserved, treated as INC.
- All address arithmetic is modulo 2^AW. INC at all-ones wraps to 0. Negative `offset` branches backward.
- States: RUN, FAULT.
  - RUN → FAULT on CALL with `ras_count`=RAS_DEPTH: code 1, no push, stack unchanged, pc=TRAP_ADDR.
  - RUN → FAULT on RET with `ras_count`=0: code 2, pc=TRAP_ADDR.
  - FAULT: pc, stack, and code hold. `en`/`op` are ignored.
  - FAULT → RUN on `clr_fault`=1: code→0, pc stays TRAP_ADDR, stack is preserved.
- `clr_fault` in RUN has no effect.
- RAS is LIFO. CALL writes `stack[count]` and increments. RET reads `stack[count-1]` and decrements.

## Timing
- Reset (async assert, synchronous to the clock on release): pc=RESET_ADDR, ras_count=0, fault=0, fault_code=0, state RUN. Stack contents are don't-care.
- Latency: one cycle. An op sampled at edge N is visible on `pc` after edge N.
- `en`=0: all state holds, regardless of `op`/`cond`.
- Back-to-back CALL/RET on consecutive cycles is legal. A RET directly after a CALL returns the pushed pc+1.
- FAULT with `clr_fault`=1 and `en`=1 in the same cycle: clear wins, op is discarded. The first op takes effect on the following cycle.
- `rst` mid-operation overrides everything, including FAULT.
- `cond` is only sampled for BRANCH. `target` is only sampled for JUMP/CALL. `offset` is only sampled for BRANCH.

## Structure
- Package `pc_pkg`:
  - `pc_op_e` enum: OP_HOLD, OP_INC, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET.
  - `pc_state_e`: ST_RUN, ST_FAULT.
  - fault code constants: FC_NONE, FC_OVF, FC_UNF.
- Sub-module `pc_ras`: parameterised LIFO (AW, RAS_DEPTH). Ports: push, pop, wdata, rdata, count, full, empty. Same clock and reset.
- Top level holds the pc register, next-pc mux, and RUN/FAULT FSM.

## Test plan
- Reset with RESET_ADDR=0x0100 → pc=0x0100, ras_count=0, fault=0. Then 3× INC → pc=0x0103. Stall cycle with op=JUMP → pc stays 0x0103.
- pc=0xFFFF, INC → 0x0000. pc=0x0010, BRANCH offset=0xFFF8 cond=1 → 0x0008. Same with cond=0 → 0x0011.
- pc=0x0020: CALL target=0x0200, then CALL 0x0300, then RET, then RET → pc sequence 0x0200, 0x0300, 0x0201, 0x0021. ras_count sequence 1, 2, 1, 0.
- RAS_DEPTH=4: 5 nested CALLs → 5th sets fault=1, fault_code=1, pc=TRAP_ADDR, ras_count=4. Then INC ignored. Then clr_fault with en=1 and op=INC → fault=0, pc=TRAP_ADDR. Then RET → pc = 4th push's return address.
- RET with empty stack → fault_code=2, pc=TRAP_ADDR. Assert `rst` asynchronously mid-cycle → immediate pc=RESET_ADDR, fault=0.
- Op 6 and op 7 behave as INC. Random op stream compared against a reference model for 10k cycles with RAS_DEPTH=1 and AW=8.
